// File: rtl/gray_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : gray_seq_checker
// Brief    : Samples a Gray-coded bus, decodes it to binary and checks that
//            every enabled sample either holds or advances by exactly one
//            count (mod 2^N). Reports per-sample step/error pulses, a lock
//            flag after LOCK_CNT consecutive steps, and a saturating error
//            count.
// Revision : 1.0 - initial release
// ============================================================================
module gray_seq_checker #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             step_ok,
    output logic             err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    // Streak only needs to count up to LOCK_CNT (it saturates there).
    localparam int                  c_streak_w = $clog2(LOCK_CNT + 1);
    localparam logic [c_streak_w-1:0] c_lock_m1  = c_streak_w'(LOCK_CNT - 1);
    localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);
    localparam logic [ERR_W-1:0]    c_err_max  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]    c_err_one  = ERR_W'(1);
    localparam logic [N-1:0]        c_bin_one  = N'(1);

    typedef enum logic [1:0] {
        c_idle   = 2'd0,
        c_track  = 2'd1,
        c_locked = 2'd2
    } state_t;

    state_t                  r_state;
    logic [N-1:0]            r_bin;        // doubles as the previous sample
    logic [c_streak_w-1:0]   r_streak;
    logic                    r_step_ok;
    logic                    r_err;
    logic                    r_locked;
    logic [ERR_W-1:0]        r_err_count;

    logic [N-1:0]            w_bin;
    logic                    w_is_step;
    logic                    w_is_hold;

    // Gray decode: binary bit i is the XOR of Gray bits N-1 down to i.
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
        assign w_bin[gi] = ^(gray_in >> gi);
    end

    // Classify the incoming sample against the previously accepted one.
    assign w_is_step = (w_bin == (r_bin + c_bin_one));
    assign w_is_hold = (w_bin == r_bin);

    // Sequence tracker: state, streak, error count and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_bin       <= '0;
            r_streak    <= '0;
            r_step_ok   <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else begin
            // Pulses default low so they never stretch across idle cycles.
            r_step_ok <= 1'b0;
            r_err     <= 1'b0;
            if (clk_en) begin
                case (r_state)
                    c_idle: begin
                        // First sample is only a reference, never judged.
                        r_bin    <= w_bin;
                        r_streak <= '0;
                        r_state  <= c_track;
                    end
                    c_track: begin
                        r_bin <= w_bin;
                        if (w_is_step) begin
                            r_step_ok <= 1'b1;
                            r_streak  <= r_streak + c_streak_one;
                            if (r_streak == c_lock_m1) begin
                                r_locked <= 1'b1;
                                r_state  <= c_locked;
                            end
                        end else if (!w_is_hold) begin
                            r_err    <= 1'b1;
                            r_streak <= '0;
                            if (r_err_count != c_err_max) begin
                                r_err_count <= r_err_count + c_err_one;
                            end
                        end
                    end
                    c_locked: begin
                        // Streak stays saturated at LOCK_CNT while locked.
                        r_bin <= w_bin;
                        if (w_is_step) begin
                            r_step_ok <= 1'b1;
                        end else if (!w_is_hold) begin
                            r_err    <= 1'b1;
                            r_streak <= '0;
                            r_locked <= 1'b0;
                            r_state  <= c_track;
                            if (r_err_count != c_err_max) begin
                                r_err_count <= r_err_count + c_err_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                    end
                endcase
            end
        end
    end

    assign bin_out   = r_bin;
    assign step_ok   = r_step_ok;
    assign err       = r_err;
    assign locked    = r_locked;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
